data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_pkg.sv | 37 +++
 rtl/dmem_ram.sv | 38 +++
 rtl/data_mem_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory controller: request/response structs, FSM states
// and the byte-lane helpers used by the controller datapath.
package data_mem_ctrl_pkg;

    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_e;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic byte_not_word);
        return byte_not_word ? (4'b0001 << lane) : 4'b1111;
    endfunction

    // Byte loads return the addressed lane zero-extended; word loads pass through.
    function automatic logic [31:0] load_format(input logic [31:0] word, input logic [1:0] lane,
                                                input logic byte_not_word);
        logic [31:0] shifted;
        shifted = word >> {lane, 3'b000};
        return byte_not_word ? {24'h0, shifted[7:0]} : word;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables; no reset on the array
// or the read register.
module dmem_ram #(
    parameter int unsigned addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [3:0]              be_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [31:0]             wdata_i,
    output logic [31:0]             rdata_o
);

    logic [31:0] mem_q [2**addr_width_p];
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (en_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: IDLE/BUSY/RESP handshake in front of dmem_ram.
// Define DMEM_ERR_EN to add misaligned/out-of-range detection and the sticky error_o flag.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned addr_width_p = 10,
    parameter int unsigned latency_p    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] addr_i,
    output mem_out_s    from_mem_o
`ifdef DMEM_ERR_EN
    ,
    output logic        error_o
`endif
);

    dmem_state_e             state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [addr_width_p-1:0] idx_q, idx_d;
    logic [1:0]              lane_q, lane_d;
    logic                    wen_q, wen_d;
    logic                    bnw_q, bnw_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    ram_en;
    logic                    suppress;
    logic [31:0]             ram_rdata;

`ifdef DMEM_ERR_EN
    logic acc_err_q, acc_err_d;
    logic error_q, error_d;
    logic new_err;

    assign new_err = (!to_mem_i.byte_not_word && (addr_i[1:0] != 2'b00)) ||
                     (addr_i[31:addr_width_p+2] != '0);
    assign suppress = acc_err_q;
    assign error_o  = error_q && !reset;
`else
    // Upper address bits are deliberately ignored so addresses wrap modulo the RAM size.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:addr_width_p+2];
    assign suppress = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lane_d  = lane_q;
        wen_d   = wen_q;
        bnw_d   = bnw_q;
        wdata_d = wdata_q;
        ram_en  = 1'b0;
`ifdef DMEM_ERR_EN
        acc_err_d = acc_err_q;
        error_d   = error_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (to_mem_i.valid) begin
                    idx_d   = addr_i[addr_width_p+1:2];
                    lane_d  = addr_i[1:0];
                    wen_d   = to_mem_i.wen;
                    bnw_d   = to_mem_i.byte_not_word;
                    wdata_d = to_mem_i.write_data;
                    cnt_d   = 3'(latency_p - 1);
                    state_d = BUSY;
`ifdef DMEM_ERR_EN
                    acc_err_d = new_err;
                    error_d   = error_q | new_err;
`endif
                end
            end
            BUSY: begin
                if (cnt_q == 3'd0) begin
                    // Gated by reset so a reset landing on the access edge aborts the write.
                    ram_en  = !reset;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (to_mem_i.yumi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
`ifdef DMEM_ERR_EN
            acc_err_q <= 1'b0;
            error_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef DMEM_ERR_EN
            acc_err_q <= acc_err_d;
            error_q   <= error_d;
`endif
        end
        idx_q   <= idx_d;
        lane_q  <= lane_d;
        wen_q   <= wen_d;
        bnw_q   <= bnw_d;
        wdata_q <= wdata_d;
    end

    dmem_ram #(
        .addr_width_p(addr_width_p)
    ) u_ram (
        .clk    (clk),
        .en_i   (ram_en),
        .we_i   (wen_q && !suppress),
        .be_i   (lane_mask(lane_q, bnw_q)),
        .addr_i (idx_q),
        .wdata_i(bnw_q ? {4{wdata_q[7:0]}} : wdata_q),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        from_mem_o = '0;
        if (!reset) begin
            from_mem_o.yumi  = (state_q == IDLE) && to_mem_i.valid;
            from_mem_o.valid = (state_q == RESP);
            if ((state_q == RESP) && !wen_q && !suppress) begin
                from_mem_o.read_data = load_format(ram_rdata, lane_q, bnw_q);
            end
        end
    end

endmodule
